// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: operation encodings, FSM states
// and the single- versus multi-cycle classification.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MULU = 4'b0010;
    localparam logic [3:0] OP_RSVD = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_DIVU = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_SLL  = 4'b1011;
    localparam logic [3:0] OP_SRL  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b1110;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, with signs applied on the result path.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             res_dbz
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               op_signed;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign op_signed = (op == OP_MUL) || (op == OP_DIV);
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    assign div_part  = {hi, lo[WIDTH-1]};
    assign div_diff  = div_part - {1'b0, mag_b};
    assign last      = (cnt == CW'(WIDTH - 1));

    // hi holds the partial product / partial remainder; lo the multiplier / quotient
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            mag_b  <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= (op_signed && a[WIDTH-1]) ? -a : a;
            mag_b  <= (op_signed && b[WIDTH-1]) ? -b : b;
            a_raw  <= a;
            is_div <= (op == OP_DIV) || (op == OP_DIVU);
            neg_lo <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi <= op_signed && a[WIDTH-1];
        end else if (step) begin
            cnt <= cnt + CW'(1);
            if (is_div) begin
                if (!div_diff[WIDTH]) begin
                    hi <= div_diff[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= div_part[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi <= mul_sum[WIDTH:1];
                lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        res_dbz  = is_div && (mag_b == '0);
        prod_fix = neg_lo ? -{hi, lo} : {hi, lo};
        if (is_div) begin
            res_lo = res_dbz ? '1    : (neg_lo ? -lo : lo);
            res_hi = res_dbz ? a_raw : (neg_hi ? -hi : hi);
        end else begin
            res_lo = prod_fix[WIDTH-1:0];
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ops resolve in IDLE, multiply/divide run
// through the iterative engine. States:
//   IDLE | accepting start; single-cycle ops complete here
//   RUN  | one mul/div step per cycle, WIDTH steps
//   FIX  | signs applied, results written, done pulsed
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   SHAMT,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] HIGH,
    output logic             Zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    state_t           state;
    state_t           state_nxt;
    logic             md_load;
    logic             md_step;
    logic             md_last;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic             md_dbz;
    logic             sc_fire;
    logic             fix_fire;
    logic [WIDTH-1:0] sc_res;

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .load    (md_load),
        .step    (md_step),
        .op      (ALUop),
        .a       (A),
        .b       (B),
        .last    (md_last),
        .res_lo  (md_lo),
        .res_hi  (md_hi),
        .res_dbz (md_dbz)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        md_load   = 1'b0;
        md_step   = 1'b0;
        sc_fire   = 1'b0;
        fix_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && is_multicycle(ALUop)) begin
                    md_load   = 1'b1;
                    state_nxt = ST_RUN;
                end else if (start) begin
                    sc_fire = 1'b1;
                end
            end
            ST_RUN: begin
                md_step = 1'b1;
                if (md_last) state_nxt = ST_FIX;
            end
            ST_FIX: begin
                fix_fire  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Shifts operate on B, matching the EX-stage shift-by-immediate form
    always_comb begin
        sc_res = '0;
        case (ALUop)
            OP_ADD:  sc_res = A + B;
            OP_SUB:  sc_res = A - B;
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_NOR:  sc_res = ~(A | B);
            OP_XOR:  sc_res = A ^ B;
            OP_SLL:  sc_res = B << SHAMT;
            OP_SRL:  sc_res = B >> SHAMT;
            OP_SRA:  sc_res = $signed(B) >>> SHAMT;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default: sc_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            S           <= '0;
            HIGH        <= '0;
            Zero        <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (sc_fire) begin
                S           <= sc_res;
                HIGH        <= '0;
                Zero        <= (sc_res == '0);
                div_by_zero <= 1'b0;
                done        <= 1'b1;
            end else if (fix_fire) begin
                S           <= md_lo;
                HIGH        <= md_hi;
                Zero        <= (md_lo == '0);
                div_by_zero <= md_dbz;
                done        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=8 and WIDTH=16: a driver pushes
// expected results from an arithmetic reference model, monitors pop on done.
module tb_seq_alu;

    localparam logic [3:0] T_ADD = 4'd0,  T_SUB = 4'd1,  T_MULU = 4'd2, T_RSVD = 4'd3;
    localparam logic [3:0] T_MUL = 4'd4,  T_DIV = 4'd5,  T_DIVU = 4'd6, T_AND = 4'd7;
    localparam logic [3:0] T_OR  = 4'd8,  T_NOR = 4'd9,  T_XOR = 4'd10, T_SLL = 4'd11;
    localparam logic [3:0] T_SRL = 4'd12, T_SRA = 4'd13, T_SLT = 4'd14, T_SLTU = 4'd15;

    typedef struct {
        longint s;
        longint hi;
        bit     dbz;
        int     issue;
        int     lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [3:0]  op8, op16;
    logic [7:0]  a8, b8, s8, hi8;
    logic [2:0]  sh8;
    logic [15:0] a16, b16, s16, hi16;
    logic [3:0]  sh16;
    logic        z8, busy8, done8, dbz8;
    logic        z16, busy16, done16, dbz16;

    exp_t q8[$];
    exp_t q16[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .ALUop(op8), .A(a8), .B(b8),
        .SHAMT(sh8), .S(s8), .HIGH(hi8), .Zero(z8), .busy(busy8), .done(done8),
        .div_by_zero(dbz8)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .ALUop(op16), .A(a16), .B(b16),
        .SHAMT(sh16), .S(s16), .HIGH(hi16), .Zero(z16), .busy(busy16), .done(done16),
        .div_by_zero(dbz16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit is_mc(input logic [3:0] op);
        return op == T_MUL || op == T_MULU || op == T_DIV || op == T_DIVU;
    endfunction

    // Reference: plain integer arithmetic on w-bit values
    function automatic void model(input int w, input logic [3:0] op, input longint a,
                                  input longint b, input int sh, output longint s,
                                  output longint hi, output bit dbz, output int lat);
        longint m, half, ia, ib, p;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ia   = (a >= half) ? a - (m + 1) : a;
        ib   = (b >= half) ? b - (m + 1) : b;
        hi   = 0;
        dbz  = 0;
        p    = 0;
        lat  = is_mc(op) ? w + 2 : 1;
        case (op)
            T_ADD:  p = a + b;
            T_SUB:  p = a - b;
            T_AND:  p = a & b;
            T_OR:   p = a | b;
            T_NOR:  p = ~(a | b);
            T_XOR:  p = a ^ b;
            T_SLL:  p = b << sh;
            T_SRL:  p = b >> sh;
            T_SRA:  p = ib >>> sh;
            T_SLT:  p = (ia < ib) ? 1 : 0;
            T_SLTU: p = (a < b) ? 1 : 0;
            T_MULU: begin p = a * b;   hi = (p >>> w) & m; end
            T_MUL:  begin p = ia * ib; hi = (p >>> w) & m; end
            T_DIV: begin
                if (b == 0) begin p = m; hi = a; dbz = 1; end
                else begin p = ia / ib; hi = (ia % ib) & m; end
            end
            T_DIVU: begin
                if (b == 0) begin p = m; hi = a; dbz = 1; end
                else begin p = a / b; hi = a % b; end
            end
            default: p = 0;
        endcase
        s = p & m;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w8_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8_S", s8, e.s);
                chk("w8_HIGH", hi8, e.hi);
                chk("w8_Zero", z8, (e.s == 0));
                chk("w8_div_by_zero", dbz8, e.dbz);
                chk("w8_latency", cyc - e.issue, e.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w16_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q16.pop_front();
                chk("w16_S", s16, e.s);
                chk("w16_HIGH", hi16, e.hi);
                chk("w16_Zero", z16, (e.s == 0));
                chk("w16_div_by_zero", dbz16, e.dbz);
                chk("w16_latency", cyc - e.issue, e.lat);
            end
        end
    end

    // Called at a negedge with dut8 idle; poke pulses start once mid-RUN.
    task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sh, input bit poke);
        exp_t e;
        int   n;
        model(8, op, longint'(a), longint'(b), int'(sh), e.s, e.hi, e.dbz, e.lat);
        e.issue = cyc;
        q8.push_back(e);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b; sh8 = sh;
        @(negedge clk);
        start8 = 1'b0;
        chk("w8_busy_after_start", busy8, is_mc(op));
        n = 0;
        while (busy8 && n < 40) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            op8 = poke ? T_ADD : 4'($urandom);
            start8 = poke && (n == 3);
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        if (busy8) chk("w8_busy_timeout", busy8, 0);
    endtask

    task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh);
        exp_t e;
        int   n;
        model(16, op, longint'(a), longint'(b), int'(sh), e.s, e.hi, e.dbz, e.lat);
        e.issue = cyc;
        q16.push_back(e);
        start16 = 1'b1; op16 = op; a16 = a; b16 = b; sh16 = sh;
        @(negedge clk);
        start16 = 1'b0;
        chk("w16_busy_after_start", busy16, is_mc(op));
        n = 0;
        while (busy16 && n < 60) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            @(negedge clk);
            n++;
        end
        if (busy16) chk("w16_busy_timeout", busy16, 0);
    endtask

    initial begin
        logic [3:0] rop;
        logic [7:0] rb;
        rst = 1'b1;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; sh8 = '0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; sh16 = '0;
        repeat (3) @(negedge clk);
        chk("reset_S", s8, 0);
        chk("reset_HIGH", hi8, 0);
        chk("reset_Zero", z8, 1);
        chk("reset_busy", busy8, 0);
        chk("reset_done", done8, 0);
        chk("reset_dbz", dbz8, 0);
        rst = 1'b0;
        @(negedge clk);

        run8(T_ADD,  8'hF0, 8'h20, 3'd0, 0);
        run8(T_SUB,  8'h05, 8'h05, 3'd0, 0);
        run8(T_MUL,  8'hFD, 8'h07, 3'd0, 0);
        run8(T_MULU, 8'hFD, 8'h07, 3'd0, 0);
        run8(T_DIV,  8'hF9, 8'h02, 3'd0, 0);
        run8(T_DIVU, 8'hF9, 8'h02, 3'd0, 0);
        run8(T_DIVU, 8'h2A, 8'h00, 3'd0, 1);
        run8(T_DIV,  8'hF9, 8'h00, 3'd0, 0);
        run8(T_DIV,  8'h80, 8'hFF, 3'd0, 0);
        run8(T_MUL,  8'h80, 8'h80, 3'd0, 0);
        run8(T_SRA,  8'h00, 8'h90, 3'd3, 0);
        run8(T_SLT,  8'hFF, 8'h01, 3'd0, 0);
        run8(T_SLTU, 8'hFF, 8'h01, 3'd0, 0);
        run8(T_RSVD, 8'h12, 8'h34, 3'd5, 0);
        run8(T_NOR,  8'h0F, 8'hF0, 3'd0, 0);
        run8(T_SLL,  8'h00, 8'h81, 3'd7, 0);

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run8(rop, 8'($urandom), rb, 3'($urandom), 0);
        end

        // Abort a multiply part-way through RUN
        start8 = 1'b1; op8 = T_MUL; a8 = 8'h37; b8 = 8'h5C;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_run_busy", busy8, 0);
        chk("rst_mid_run_S", s8, 0);
        chk("rst_mid_run_HIGH", hi8, 0);
        chk("rst_mid_run_Zero", z8, 1);
        chk("rst_mid_run_done", done8, 0);
        repeat (12) @(negedge clk);
        run8(T_ADD, 8'h01, 8'h02, 3'd0, 0);

        run16(T_MUL,  16'hFFFD, 16'h0007, 4'd0);
        run16(T_MULU, 16'hFFFD, 16'h0007, 4'd0);
        run16(T_DIV,  16'hFFF9, 16'h0002, 4'd0);
        run16(T_DIVU, 16'hFFF9, 16'h0002, 4'd0);
        run16(T_DIVU, 16'h002A, 16'h0000, 4'd0);
        run16(T_DIV,  16'h8000, 16'hFFFF, 4'd0);
        run16(T_SRA,  16'h0000, 16'h9000, 4'd11);
        for (int i = 0; i < 40; i++)
            run16(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 4'($urandom));

        repeat (4) @(negedge clk);
        chk("w8_queue_drained", q8.size(), 0);
        chk("w16_queue_drained", q16.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
